// File: rtl/stereo_pair_aligner_if.sv
// stereo_pair_aligner_if: sample inputs, codec write port and status of the stereo pair aligner.
// The master modport is the producer/consumer side; the slave modport is the aligner itself.
interface stereo_pair_aligner_if #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [W-1:0]  left_in;
  logic          left_valid;
  logic [W-1:0]  right_in;
  logic          right_valid;
  logic          write_ready;
  logic          write;
  logic [W-1:0]  left_out;
  logic [W-1:0]  right_out;
  logic [LW-1:0] left_level;
  logic [LW-1:0] right_level;
  logic          overflow;

  modport master (
    output left_in, left_valid, right_in, right_valid, write_ready,
    input  write, left_out, right_out, left_level, right_level, overflow
  );

  modport slave (
    input  left_in, left_valid, right_in, right_valid, write_ready,
    output write, left_out, right_out, left_level, right_level, overflow
  );
endinterface

// File: rtl/stereo_pair_aligner.sv
// stereo_pair_aligner: buffers left (raw) and right (FIR) samples in two small FIFOs
// and emits matched pairs to the codec as single-cycle write strobes.
// Optional macro STEREO_ALIGN_RESYNC_EN: any overflow flushes both FIFOs to restore alignment.
module stereo_pair_aligner #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                ck,
  input  logic                rst_n,
  stereo_pair_aligner_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    FIRE = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          pop_c;

  logic [W-1:0]  mem_l [DEPTH];
  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_l;
  logic [AW-1:0] rd_l;
  logic [AW-1:0] wr_r;
  logic [AW-1:0] rd_r;
  logic [LW-1:0] lvl_l;
  logic [LW-1:0] lvl_r;

  logic          ovf_l_c;
  logic          ovf_r_c;
  logic          ovf_c;
  logic          flush_c;
  logic          acc_l;
  logic          acc_r;

  logic          write_q;
  logic [W-1:0]  left_q;
  logic [W-1:0]  right_q;
  logic          ovf_q;

  // FSM state register
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; a pair pops on the IDLE->FIRE edge when both sides hold data
  always_comb begin
    state_nxt = state;
    pop_c     = 1'b0;
    case (state)
      IDLE: begin
        if ((lvl_l != '0) && (lvl_r != '0) && bus.write_ready) begin
          pop_c     = 1'b1;
          state_nxt = FIRE;
        end
      end
      FIRE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Push acceptance; a pop in the same cycle frees a slot in a full FIFO
  always_comb begin
    ovf_l_c = bus.left_valid && (lvl_l == FULL) && !pop_c;
    ovf_r_c = bus.right_valid && (lvl_r == FULL) && !pop_c;
    ovf_c   = ovf_l_c || ovf_r_c;
`ifdef STEREO_ALIGN_RESYNC_EN
    flush_c = ovf_c;
`else
    flush_c = 1'b0;
`endif
    acc_l   = bus.left_valid && !ovf_l_c && !flush_c;
    acc_r   = bus.right_valid && !ovf_r_c && !flush_c;
  end

  // Sample storage; stale contents are harmless since levels gate every read
  always_ff @(posedge ck) begin
    if (acc_l) begin
      mem_l[wr_l] <= bus.left_in;
    end
    if (acc_r) begin
      mem_r[wr_r] <= bus.right_in;
    end
  end

  // Pointer, level and sticky overflow bookkeeping for both FIFOs
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      wr_l  <= '0;
      rd_l  <= '0;
      lvl_l <= '0;
      wr_r  <= '0;
      rd_r  <= '0;
      lvl_r <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (ovf_c) begin
        ovf_q <= 1'b1;
      end
      if (flush_c) begin
        wr_l  <= '0;
        rd_l  <= '0;
        lvl_l <= '0;
        wr_r  <= '0;
        rd_r  <= '0;
        lvl_r <= '0;
      end else begin
        if (acc_l) wr_l <= wr_l + AW'(1);
        if (acc_r) wr_r <= wr_r + AW'(1);
        if (pop_c) begin
          rd_l <= rd_l + AW'(1);
          rd_r <= rd_r + AW'(1);
        end
        if (acc_l && !pop_c) begin
          lvl_l <= lvl_l + LW'(1);
        end else if (!acc_l && pop_c) begin
          lvl_l <= lvl_l - LW'(1);
        end
        if (acc_r && !pop_c) begin
          lvl_r <= lvl_r + LW'(1);
        end else if (!acc_r && pop_c) begin
          lvl_r <= lvl_r - LW'(1);
        end
      end
    end
  end

  // Output pair and write strobe; data holds until the next pop
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      write_q <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      write_q <= pop_c;
      if (pop_c) begin
        left_q  <= mem_l[rd_l];
        right_q <= mem_r[rd_r];
      end
    end
  end

  assign bus.write       = write_q;
  assign bus.left_out    = left_q;
  assign bus.right_out   = right_q;
  assign bus.left_level  = lvl_l;
  assign bus.right_level = lvl_r;
  assign bus.overflow    = ovf_q;

endmodule
